// File: rtl/mips_pkg.sv
// Shared encodings and defaults for the MIPS pipeline control blocks.
package mips_pkg;

   localparam logic [1:0] TUSE_NONE       = 2'd3;
   localparam logic [4:0] REG_ZERO        = 5'd0;
   localparam int         MULT_CYCLES_DEF = 5;
   localparam int         DIV_CYCLES_DEF  = 10;

   // A Tuse of TUSE_NONE can never be below a 2-bit Tnew, so unused sources drop out naturally.
   function automatic logic reg_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                       input logic [4:0] wa, input logic [1:0] tnew);
      return (src != REG_ZERO) && (src == wa) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/md_busy_seq.sv
// Multiply/divide busy sequencer: down-counter loaded on each start, busy while counting.
module md_busy_seq
   import mips_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start,
   input  logic md_is_div,
   output logic md_busy
);

   logic [CNT_W-1:0] md_cnt_q;
   logic [CNT_W-1:0] md_cnt_d;

   // A start while already counting simply reloads; no error is flagged.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_start) begin
         md_cnt_d = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

   assign md_busy = md_start || (md_cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: register Tuse/Tnew checks plus MDU busy interlock.
// Optional macro HAZARD_STAT_EN adds stall_cnt and md_stall_cnt statistics outputs.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [1:0]  id_tuse_rs,
   input  logic [1:0]  id_tuse_rt,
   input  logic        id_is_md,
   input  logic [4:0]  ex_wa,
   input  logic [1:0]  ex_tnew,
   input  logic [4:0]  mem_wa,
   input  logic [1:0]  mem_tnew,
   input  logic        md_start,
   input  logic        md_is_div,
`ifdef HAZARD_STAT_EN
   output logic [31:0] stall_cnt,
   output logic [31:0] md_stall_cnt,
`endif
   output logic        en_if,
   output logic        en_d,
   output logic        flush_e,
   output logic        md_busy
);

   logic stall_rs;
   logic stall_rt;
   logic stall_md;
   logic stall;

   md_busy_seq #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_md_busy_seq (
      .clk      (clk),
      .reset    (reset),
      .md_start (md_start),
      .md_is_div(md_is_div),
      .md_busy  (md_busy)
   );

   assign stall_rs = reg_hazard(id_rs, id_tuse_rs, ex_wa, ex_tnew)
                  || reg_hazard(id_rs, id_tuse_rs, mem_wa, mem_tnew);
   assign stall_rt = reg_hazard(id_rt, id_tuse_rt, ex_wa, ex_tnew)
                  || reg_hazard(id_rt, id_tuse_rt, mem_wa, mem_tnew);
   assign stall_md = id_is_md && md_busy;
   assign stall    = stall_rs || stall_rt || stall_md;

   // One bubble per stalled cycle regardless of how many causes coincide.
   assign en_if   = !stall;
   assign en_d    = !stall;
   assign flush_e = stall;

`ifdef HAZARD_STAT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;
   logic [31:0] md_stall_cnt_q;
   logic [31:0] md_stall_cnt_d;

   always_comb begin
      stall_cnt_d    = stall_cnt_q;
      md_stall_cnt_d = md_stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (stall_md && (md_stall_cnt_q != 32'hFFFF_FFFF)) begin
         md_stall_cnt_d = md_stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q    <= '0;
         md_stall_cnt_q <= '0;
      end else begin
         stall_cnt_q    <= stall_cnt_d;
         md_stall_cnt_q <= md_stall_cnt_d;
      end
   end

   assign stall_cnt    = stall_cnt_q;
   assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed MDU/reset sequences, random vs. model.
module tb_hazard_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_wa, mem_wa;
   logic [1:0]  id_tuse_rs, id_tuse_rt, ex_tnew, mem_tnew;
   logic        id_is_md, md_start, md_is_div;
   logic        en_if, en_d, flush_e, md_busy;
`ifdef HAZARD_STAT_EN
   logic [31:0] stall_cnt, md_stall_cnt;
`endif

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_tuse_rs  (id_tuse_rs),
      .id_tuse_rt  (id_tuse_rt),
      .id_is_md    (id_is_md),
      .ex_wa       (ex_wa),
      .ex_tnew     (ex_tnew),
      .mem_wa      (mem_wa),
      .mem_tnew    (mem_tnew),
      .md_start    (md_start),
      .md_is_div   (md_is_div),
`ifdef HAZARD_STAT_EN
      .stall_cnt   (stall_cnt),
      .md_stall_cnt(md_stall_cnt),
`endif
      .en_if       (en_if),
      .en_d        (en_d),
      .flush_e     (flush_e),
      .md_busy     (md_busy)
   );

   typedef struct {
      logic [4:0] rs, rt;
      logic [1:0] tuse_rs, tuse_rt;
      logic       is_md;
      logic [4:0] ex_wa;
      logic [1:0] ex_tnew;
      logic [4:0] mem_wa;
      logic [1:0] mem_tnew;
      logic       md_start, md_is_div, rst;
   } stim_t;

   typedef struct {
      stim_t s;
      logic  exp_stall;
      string name;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   // Reference state: cycle index and the last cycle an MDU op keeps the unit busy.
   int cyc      = 0;
   int last_end = -1;
   int m_stall  = 0;
   int m_md     = 0;
   bit busy_exp;
   bit stall_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.rs = 0; s.rt = 0; s.tuse_rs = 2'd3; s.tuse_rt = 2'd3; s.is_md = 0;
      s.ex_wa = 0; s.ex_tnew = 0; s.mem_wa = 0; s.mem_tnew = 0;
      s.md_start = 0; s.md_is_div = 0; s.rst = 0;
      return s;
   endfunction

   function automatic bit src_stalls(input int src, input int tuse, input stim_t s);
      if (src == 0) return 0;
      if (src == int'(s.ex_wa) && tuse < int'(s.ex_tnew)) return 1;
      if (src == int'(s.mem_wa) && tuse < int'(s.mem_tnew)) return 1;
      return 0;
   endfunction

   function automatic bit ref_reg_stall(input stim_t s);
      return src_stalls(int'(s.rs), int'(s.tuse_rs), s) || src_stalls(int'(s.rt), int'(s.tuse_rt), s);
   endfunction

   task automatic step(input stim_t s, input string tag, input bit do_chk);
      @(negedge clk);
      reset = s.rst; id_rs = s.rs; id_rt = s.rt; id_tuse_rs = s.tuse_rs; id_tuse_rt = s.tuse_rt;
      id_is_md = s.is_md; ex_wa = s.ex_wa; ex_tnew = s.ex_tnew; mem_wa = s.mem_wa;
      mem_tnew = s.mem_tnew; md_start = s.md_start; md_is_div = s.md_is_div;
      #1;
      busy_exp  = s.md_start || (cyc <= last_end);
      stall_exp = ref_reg_stall(s) || (s.is_md && busy_exp);
      if (do_chk) begin
         chk({tag, "_en_if"},   32'(en_if),   32'(!stall_exp));
         chk({tag, "_en_d"},    32'(en_d),    32'(!stall_exp));
         chk({tag, "_flush_e"}, 32'(flush_e), 32'(stall_exp));
         chk({tag, "_md_busy"}, 32'(md_busy), 32'(busy_exp));
`ifdef HAZARD_STAT_EN
         chk({tag, "_stall_cnt"},    stall_cnt,    32'(m_stall));
         chk({tag, "_md_stall_cnt"}, md_stall_cnt, 32'(m_md));
`endif
      end
      if (s.rst) begin
         last_end = -1;
         m_stall  = 0;
         m_md     = 0;
      end else begin
         if (s.md_start) last_end = cyc + (s.md_is_div ? DIV_N : MULT_N);
         if (stall_exp) m_stall++;
         if (s.is_md && busy_exp) m_md++;
      end
      cyc++;
   endtask

   vec_t  vecs[8];
   stim_t s;

   initial begin
      for (int i = 0; i < 8; i++) begin
         vecs[i].s = idle();
      end
      vecs[0].name = "load_use";   vecs[0].s.ex_wa = 8; vecs[0].s.ex_tnew = 2; vecs[0].s.rs = 8; vecs[0].s.tuse_rs = 1; vecs[0].exp_stall = 1;
      vecs[1].name = "load_rel";   vecs[1].s.mem_wa = 8; vecs[1].s.mem_tnew = 1; vecs[1].s.rs = 8; vecs[1].s.tuse_rs = 1; vecs[1].exp_stall = 0;
      vecs[2].name = "zero_reg";   vecs[2].s.ex_wa = 0; vecs[2].s.ex_tnew = 2; vecs[2].s.rs = 0; vecs[2].s.tuse_rs = 0; vecs[2].exp_stall = 0;
      vecs[3].name = "rt_unused";  vecs[3].s.ex_wa = 9; vecs[3].s.ex_tnew = 2; vecs[3].s.rt = 9; vecs[3].s.tuse_rt = 3; vecs[3].exp_stall = 0;
      vecs[4].name = "tnew_zero";  vecs[4].s.ex_wa = 5; vecs[4].s.ex_tnew = 0; vecs[4].s.rs = 5; vecs[4].s.tuse_rs = 0; vecs[4].exp_stall = 0;
      vecs[5].name = "rt_mem";     vecs[5].s.mem_wa = 7; vecs[5].s.mem_tnew = 2; vecs[5].s.rt = 7; vecs[5].s.tuse_rt = 0; vecs[5].exp_stall = 1;
      vecs[6].name = "tuse_eq";    vecs[6].s.ex_wa = 4; vecs[6].s.ex_tnew = 2; vecs[6].s.rs = 4; vecs[6].s.tuse_rs = 2; vecs[6].exp_stall = 0;
      vecs[7].name = "both_src";   vecs[7].s.ex_wa = 3; vecs[7].s.ex_tnew = 1; vecs[7].s.rs = 3; vecs[7].s.tuse_rs = 0;
                                   vecs[7].s.mem_wa = 6; vecs[7].s.mem_tnew = 3; vecs[7].s.rt = 6; vecs[7].s.tuse_rt = 2; vecs[7].exp_stall = 1;

      // Reset, then idle-state check.
      s = idle(); s.rst = 1;
      step(s, "rst0", 0);
      step(s, "rst1", 1);
      s = idle();
      step(s, "idle", 1);
      chk("idle_en_if", 32'(en_if), 32'd1);
      chk("idle_flush", 32'(flush_e), 32'd0);
      chk("idle_busy", 32'(md_busy), 32'd0);

      foreach (vecs[i]) begin
         step(vecs[i].s, vecs[i].name, 1);
         chk({vecs[i].name, "_tbl_flush"}, 32'(flush_e), 32'(vecs[i].exp_stall));
         chk({vecs[i].name, "_tbl_en_if"}, 32'(en_if), 32'(!vecs[i].exp_stall));
      end

      // Mult start at t with dependent MD instr held: blocked t..t+5, free at t+6.
      for (int i = 0; i <= 6; i++) begin
         s = idle(); s.is_md = 1; s.md_start = (i == 0); s.md_is_div = 0;
         step(s, "mult", 1);
         chk("mult_flush_seq", 32'(flush_e), 32'(i <= 5));
      end

      // Div at t, mult restart at t+3: busy through t+8, idle at t+9.
      for (int i = 0; i <= 10; i++) begin
         s = idle(); s.md_start = (i == 0 || i == 3); s.md_is_div = (i == 0);
         step(s, "restart", 1);
         chk("restart_busy_seq", 32'(md_busy), 32'(i <= 8));
      end

      // Reset mid-div abandons the count.
      for (int i = 0; i <= 5; i++) begin
         s = idle(); s.md_start = (i == 0); s.md_is_div = 1; s.rst = (i == 4); s.is_md = (i == 5);
         step(s, "rstmid", 1);
         if (i == 3) chk("rstmid_busy_before", 32'(md_busy), 32'd1);
         if (i == 5) begin
            chk("rstmid_busy_after", 32'(md_busy), 32'd0);
            chk("rstmid_en_if_after", 32'(en_if), 32'd1);
         end
      end

      // Start coinciding with reset leaves the counter clear.
      s = idle(); s.md_start = 1; s.md_is_div = 1; s.rst = 1;
      step(s, "start_rst", 1);
      s = idle(); s.is_md = 1;
      step(s, "start_rst_next", 1);
      chk("start_rst_busy", 32'(md_busy), 32'd0);

`ifdef HAZARD_STAT_EN
      s = idle(); s.rst = 1;
      step(s, "stat_rst", 1);
      for (int i = 0; i < 3; i++) begin
         s = vecs[0].s;
         step(s, "stat_lu", 1);
      end
      for (int i = 0; i <= 6; i++) begin
         s = idle(); s.is_md = 1; s.md_start = (i == 0);
         step(s, "stat_md", 1);
      end
      s = idle();
      step(s, "stat_end", 1);
      chk("stat_stall_cnt_9", stall_cnt, 32'd9);
      chk("stat_md_stall_cnt_6", md_stall_cnt, 32'd6);
`endif

      // Random traffic against the reference model.
      for (int n = 0; n < 600; n++) begin
         s.rs        = 5'($urandom_range(0, 3));
         s.rt        = 5'($urandom_range(0, 3));
         s.tuse_rs   = 2'($urandom_range(0, 3));
         s.tuse_rt   = 2'($urandom_range(0, 3));
         s.is_md     = 1'($urandom_range(0, 1));
         s.ex_wa     = 5'($urandom_range(0, 3));
         s.ex_tnew   = 2'($urandom_range(0, 3));
         s.mem_wa    = 5'($urandom_range(0, 3));
         s.mem_tnew  = 2'($urandom_range(0, 3));
         s.md_start  = ($urandom_range(0, 9) == 0);
         s.md_is_div = 1'($urandom_range(0, 1));
         s.rst       = ($urandom_range(0, 79) == 0);
         step(s, "rand", 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
